copperv_read_arbiter: RTL

//  Shares one memory read port between the copperv instruction-fetch (i_*) and load (d_*) read channels.

---
 rtl/copperv_read_arbiter_pkg.sv | 25 ++
 rtl/copperv_read_arbiter_if.sv | 26 ++
 rtl/copperv_read_arbiter_arb_id_fifo.sv | 83 ++++++++
 rtl/copperv_read_arbiter.sv | 129 ++++++++++++
 4 files changed

// File: rtl/copperv_read_arbiter_pkg.sv
// Shared definitions for the copperv read arbiter.
//   SRC_I / SRC_D : source IDs recorded for every accepted read address
//   src_id_t      : 1-bit source ID type stored in the ID FIFO
//   arb_state_t   : address-arbiter state (open, or holding a grant until accepted)
//   other_src()   : the source that round-robin prefers after a grant to the given one
package copperv_read_arbiter_pkg;

    localparam int ID_W = 1;

    typedef logic [ID_W-1:0] src_id_t;

    localparam src_id_t SRC_I = 1'b0;
    localparam src_id_t SRC_D = 1'b1;

    typedef enum logic [1:0] {
        ARB_OPEN   = 2'd0,
        ARB_HOLD_I = 2'd1,
        ARB_HOLD_D = 2'd2
    } arb_state_t;

    function automatic src_id_t other_src(input src_id_t id);
        return ~id;
    endfunction

endpackage

// File: rtl/copperv_read_arbiter_if.sv
// One read channel: an address request path and a returning data path.
//   raddr_valid/raddr_ready/raddr : address handshake, requester -> responder
//   rdata_valid/rdata_ready/rdata : data handshake, responder -> requester
// Modports:
//   master : the side issuing addresses and consuming data (core, or the arbiter towards memory)
//   slave  : the side accepting addresses and producing data (memory, or the arbiter towards the core)
interface copperv_read_arbiter_if #(
    parameter int bus_width = 32
);
    logic                 raddr_valid;
    logic                 raddr_ready;
    logic [bus_width-1:0] raddr;
    logic                 rdata_valid;
    logic                 rdata_ready;
    logic [bus_width-1:0] rdata;

    modport master (
        output raddr_valid, raddr, rdata_ready,
        input  raddr_ready, rdata_valid, rdata
    );

    modport slave (
        input  raddr_valid, raddr, rdata_ready,
        output raddr_ready, rdata_valid, rdata
    );
endinterface

// File: rtl/copperv_read_arbiter_arb_id_fifo.sv
// arb_id_fifo: synchronous FIFO of source IDs, one entry per accepted read address
// still waiting for its data.
//   clk, rst  : clock and synchronous active-high reset (empties the FIFO)
//   push_i    : write din_i (ignored while full, even if a pop happens the same cycle)
//   pop_i     : drop the head entry (ignored while empty)
//   din_i     : source ID to store
//   full_o    : DEPTH entries held
//   empty_o   : no entries held
//   head_o    : oldest entry, valid only when !empty_o
module arb_id_fifo
    import copperv_read_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push_i,
    input  logic    pop_i,
    input  src_id_t din_i,
    output logic    full_o,
    output logic    empty_o,
    output src_id_t head_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    src_id_t          mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // Full check uses the registered count only, so a pop cannot make room
    // for a push in the same cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset: an entry is only read after being written.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (do_push && (wr_ptr_q == PTR_W'(gi))) begin
                mem_q[gi] <= din_i;
            end
        end
    end

endmodule

// File: rtl/copperv_read_arbiter.sv
// copperv_read_arbiter: shares one memory read port between the instruction-fetch
// channel and the load channel.
//   clk, rst : clock and synchronous active-high reset
//   i_bus    : fetch read channel (arbiter acts as responder)
//   d_bus    : load read channel (arbiter acts as responder)
//   m_bus    : memory read channel (arbiter acts as requester)
// Addresses are granted round-robin with a zero-cycle path to m_bus. Once a grant
// has been presented without acceptance it is held on that source until the
// address handshake. The source of each accepted address is queued, and returning
// data is steered to the source at the queue head, so memory must answer in order.
module copperv_read_arbiter
    import copperv_read_arbiter_pkg::*;
#(
    parameter int bus_width       = 32,
    parameter int max_outstanding = 2
) (
    input logic                   clk,
    input logic                   rst,
    copperv_read_arbiter_if.slave  i_bus,
    copperv_read_arbiter_if.slave  d_bus,
    copperv_read_arbiter_if.master m_bus
);

    arb_state_t           state_q, state_d;
    src_id_t              rr_q, rr_d;
    logic                 grant_valid;
    src_id_t              grant_id;
    logic [bus_width-1:0] grant_addr;
    logic                 addr_hs;
    logic                 data_hs;
    logic                 data_route_en;
    logic                 fifo_full;
    logic                 fifo_empty;
    src_id_t              head_id;

    // ------------------------------------------------------------------
    // Address arbitration: grant selection and next state
    // ------------------------------------------------------------------
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = rr_q;
        state_d     = state_q;
        rr_d        = rr_q;

        case (state_q)
            ARB_HOLD_I: begin
                grant_valid = i_bus.raddr_valid;
                grant_id    = SRC_I;
            end
            ARB_HOLD_D: begin
                grant_valid = d_bus.raddr_valid;
                grant_id    = SRC_D;
            end
            default: begin
                grant_valid = i_bus.raddr_valid || d_bus.raddr_valid;
                if (i_bus.raddr_valid && d_bus.raddr_valid) begin
                    grant_id = rr_q;
                end else if (d_bus.raddr_valid) begin
                    grant_id = SRC_D;
                end else begin
                    grant_id = SRC_I;
                end
            end
        endcase

        // Nothing is presented while reset is asserted.
        if (rst) begin
            grant_valid = 1'b0;
        end

        // addr_hs is a function of grant_valid/fifo_full/m ready, computed below.
        if (addr_hs) begin
            state_d = ARB_OPEN;
            rr_d    = other_src(grant_id);
        end else if (grant_valid) begin
            // Presented but not taken: pin the grant so the address stays stable.
            state_d = (grant_id == SRC_D) ? ARB_HOLD_D : ARB_HOLD_I;
        end
    end

    assign grant_addr = (grant_id == SRC_D) ? d_bus.raddr : i_bus.raddr;

    // A full ID FIFO stalls the address side; there is nowhere to record the source.
    assign m_bus.raddr_valid = grant_valid && !fifo_full;
    assign m_bus.raddr       = grant_addr;
    assign addr_hs           = m_bus.raddr_valid && m_bus.raddr_ready;

    assign i_bus.raddr_ready = grant_valid && (grant_id == SRC_I) && m_bus.raddr_ready && !fifo_full;
    assign d_bus.raddr_ready = grant_valid && (grant_id == SRC_D) && m_bus.raddr_ready && !fifo_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_OPEN;
            rr_q    <= SRC_D;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
        end
    end

    // ------------------------------------------------------------------
    // Read data routing
    // ------------------------------------------------------------------
    // With no recorded source, data is ignored; it can only be a stray beat.
    assign data_route_en = !rst && !fifo_empty;

    assign i_bus.rdata_valid = data_route_en && (head_id == SRC_I) && m_bus.rdata_valid;
    assign d_bus.rdata_valid = data_route_en && (head_id == SRC_D) && m_bus.rdata_valid;
    assign i_bus.rdata       = m_bus.rdata;
    assign d_bus.rdata       = m_bus.rdata;

    assign m_bus.rdata_ready = data_route_en &&
                               ((head_id == SRC_D) ? d_bus.rdata_ready : i_bus.rdata_ready);
    assign data_hs           = m_bus.rdata_valid && m_bus.rdata_ready;

    arb_id_fifo #(
        .DEPTH (max_outstanding)
    ) u_id_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (addr_hs),
        .pop_i   (data_hs),
        .din_i   (grant_id),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (head_id)
    );

endmodule
